uart_sec_ded_top: RTL and testbench
===================================

# uart_sec_ded_top

Full-duplex UART with single-error-correct / double-error-detect (SEC-DED) protection, sitting between a simple bus-side byte interface and the serial `tx`/`rx` pins. Each byte is buffered in a TX FIFO, encoded to a 13-bit extended Hamming codeword and shifted out. Received codewords are oversampled, decoded and corrected, then buffered in an RX FIFO for the bus to read. One shared baud-tick generator drives both directions.

## Interface
- `DATA_SIZE`, 8: payload byte width.
- `SIZE_FIFO`, 16: depth of each FIFO, power of two.
- `SYS_FREQ`, 50000000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `SAMPLE`, 16: oversampling ticks per bit.
- Derived: `BAUD_DVSR = SYS_FREQ/(SAMPLE*BAUD_RATE)`, integer floor (27 at defaults).

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `rx` in 1: serial input, idle high.
- `tx` out 1: serial output, idle high.
- `trans` in 1: write request for `bus_data_in`.
- `bus_data_in` in 8: byte to transmit.
- `TX_status_register` out 3: [2] TX FIFO full, [1] TX FIFO empty, [0] transmitter busy.
- `baud_en` out 1: high while a TX frame is in progress (same as TX busy).
- `read_en` in 1: pop request for the RX FIFO.
- `rx_data_out` out 8: head of the RX FIFO (first-word fall-through).
- `RX_status_register` out 3: [2] last frame uncorrectable, [1] last frame single-bit corrected, [0] RX FIFO empty.
- `wait_request_read` out 1: RX FIFO empty.
- `wait_request_write` out 1: TX FIFO full.
- `s_tick` out 1: one-cycle baud tick.

## Operation
- **Baud generator**
  - Counter runs 0..`BAUD_DVSR`-1.
  - `s_tick`=1 for one cycle when the counter equals `BAUD_DVSR`-1.
- **TX write**
  - A byte is pushed when `trans`=1, `s_tick`=1 and the TX FIFO is not full.
  - When the FIFO is full, the write is ignored. Data is not lost silently: the source must watch `wait_request_write`.
- **Encoder**
  - Hamming(12,8) code: positions 1..12. Parity bits sit at positions 1, 2, 4, 8; data bits d0..d7 sit at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - Each parity bit gives even parity over the positions whose index has that bit set.
  - p0 is even parity over all 12 code bits.
- **TX FSM** (IDLE, START, DATA, STOP)
  - IDLE, with the FIFO not empty: pop, encode, go to START.
  - START: `tx`=0 for 16 ticks.
  - DATA: positions 1..12 are sent, then p0, 16 ticks each.
  - STOP: `tx`=1 for 16 ticks, then back to IDLE. A new frame starts immediately if the FIFO holds data.
- **RX FSM** (IDLE, START, DATA, STOP)
  - IDLE: `rx`=0 starts tick counting.
  - START: at tick 7, `rx` must still be 0. Otherwise return to IDLE (glitch).
  - DATA: each bit is sampled after 16 further ticks (mid-bit).
  - STOP: the stop bit is sampled. If the stop bit is 0, the frame is discarded and status is unchanged.
- **Decoder**
  - s = syndrome (XOR of indices of set bits); P = overall parity.
  - s=0 and P ok: clean.
  - s≠0 and P bad with s≤12: flip position s, single error.
  - s=0 and P bad: p0 is in error, data is good, single error.
  - s≠0 and P ok, or s>12: double error.
- **RX store**
  - Clean and corrected bytes are pushed to the RX FIFO. Uncorrectable bytes are discarded.
  - `RX_status_register[2:1]` is updated at every completed valid frame.
  - When the RX FIFO is full, the new byte is dropped.
- **RX read**
  - `read_en`=1 with the FIFO not empty pops at the clock edge. `rx_data_out` then shows the next entry.
  - `read_en` on an empty FIFO is ignored.
  - Simultaneous push and pop when neither full nor empty: both happen.

## Timing
- **Reset values**
  - `tx`=1, `baud_en`=0, `s_tick`=0, `rx_data_out`=0.
  - `TX_status_register`=3'b010, `RX_status_register`=3'b001.
  - `wait_request_read`=1, `wait_request_write`=0.
  - FIFOs are empty, FSMs are in IDLE, counters are 0.
- Reset mid-frame aborts immediately; `tx` returns to 1 asynchronously.
- Bit time is 16·`BAUD_DVSR` cycles (432 at defaults). A frame is 15 bits (6480 cycles).
- TX start bit begins at most one tick after the byte enters an empty FIFO and the FSM is idle.
- RX byte is visible on `rx_data_out` the cycle after stop-bit sampling.
- All status outputs are registered or derived from registered counts; no combinational path from `rx`.

## Configuration
- `UART_SECDED_EN` defined:
  - 13-bit codeword frames as above.
- `UART_SECDED_EN` not defined:
  - Plain frame of start, 8 data bits LSB first, stop.
  - Encoder and decoder are removed.
  - `RX_status_register[2:1]` are tied to 0.

## Test plan
- Reset, then idle 1000 cycles -> `tx`=1, `TX_status_register`=3'b010, `RX_status_register`=3'b001, `s_tick` period 27 cycles.
- `tx` looped to `rx`; write 8'hFF, 8'h55, 8'hAB, 8'hCD, 8'hEA, wait 40000 cycles, then pulse `read_en` five times -> `rx_data_out` reads FF, 55, AB, CD, EA in order; `RX_status_register`=3'b001 after the last pop; no error flags.
- Inject 8'hA5 codeword with position 6 flipped on `rx` -> 8'hA5 stored, `RX_status_register[1]`=1.
- Inject 8'hA5 codeword with positions 3 and 9 flipped -> nothing stored, `RX_status_register[2]`=1, `wait_request_read` stays 1.
- Write 17 bytes with the transmitter's `rx` held high -> `wait_request_write`=1 after 16 are queued (one may already be in shift); excess write ignored.
- Assert `reset_n`=0 during the DATA state of a TX frame -> `tx`=1 immediately, FIFO empty, no partial frame resumes after release.

Source files
------------

// File: rtl/uart_sec_ded_top.sv
// Full-duplex UART with TX/RX FIFOs and a shared baud-tick generator.
// Define UART_SECDED_EN for 13-bit Hamming(12,8)+overall-parity frames; otherwise plain 8-bit frames.
module uart_sec_ded_top #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned SIZE_FIFO = 16,
  parameter int unsigned SYS_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned SAMPLE    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 trans,
  input  logic [DATA_SIZE-1:0] bus_data_in,
  output logic [2:0]           TX_status_register,
  output logic                 baud_en,
  input  logic                 read_en,
  output logic [DATA_SIZE-1:0] rx_data_out,
  output logic [2:0]           RX_status_register,
  output logic                 wait_request_read,
  output logic                 wait_request_write,
  output logic                 s_tick
);
  localparam int unsigned BAUD_DVSR = SYS_FREQ / (SAMPLE * BAUD_RATE);
  localparam int unsigned DW = $clog2(BAUD_DVSR + 1);
  localparam int unsigned AW = $clog2(SIZE_FIFO);
  localparam int unsigned SW = $clog2(SAMPLE);
`ifdef UART_SECDED_EN
  localparam int unsigned NB = 13;
`else
  localparam int unsigned NB = DATA_SIZE;
`endif
  localparam int unsigned NW = $clog2(NB);
  localparam logic [SW-1:0] S_LAST = SW'(SAMPLE - 1);
  localparam logic [SW-1:0] S_MID  = SW'(SAMPLE / 2 - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NB - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

`ifdef UART_SECDED_EN
  // Codeword bit i-1 holds code position i (1..12); bit 12 holds the overall parity p0.
  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:1] c;
    c = '0;
    {c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]} = d;
    c[1] = c[3] ^ c[5] ^ c[7] ^ c[9]  ^ c[11];
    c[2] = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
    c[4] = c[5] ^ c[6] ^ c[7] ^ c[12];
    c[8] = c[9] ^ c[10] ^ c[11] ^ c[12];
    return {^c, c};
  endfunction

  // Returns {double_error, single_error, corrected_byte}.
  function automatic logic [9:0] decode(input logic [12:0] cw);
    logic [12:1] c;
    logic [3:0]  s;
    logic        p, sgl, dbl;
    c    = cw[11:0];
    s[0] = c[1] ^ c[3] ^ c[5] ^ c[7]  ^ c[9]  ^ c[11];
    s[1] = c[2] ^ c[3] ^ c[6] ^ c[7]  ^ c[10] ^ c[11];
    s[2] = c[4] ^ c[5] ^ c[6] ^ c[7]  ^ c[12];
    s[3] = c[8] ^ c[9] ^ c[10] ^ c[11] ^ c[12];
    p    = ^cw;
    sgl  = 1'b0;
    dbl  = 1'b0;
    if (s == 4'd0) begin
      sgl = p;
    end else if (p && s <= 4'd12) begin
      c   = c ^ (12'd1 << (s - 4'd1));
      sgl = 1'b1;
    end else begin
      dbl = 1'b1;
    end
    return {dbl, sgl, c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]};
  endfunction
`endif

  // Baud tick generator
  logic [DW-1:0] baud_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              baud_cnt <= '0;
    else if (baud_cnt == DW'(BAUD_DVSR - 1))   baud_cnt <= '0;
    else                                       baud_cnt <= baud_cnt + 1'b1;
  end
  assign s_tick = (baud_cnt == DW'(BAUD_DVSR - 1));

  // TX FIFO
  logic [DATA_SIZE-1:0] tx_mem [SIZE_FIFO];
  logic [AW:0]          tx_wr, tx_rd;
  logic                 tx_full, tx_empty, tx_push, tx_pop;
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign tx_push  = trans && s_tick && !tx_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
    end
  end
  always_ff @(posedge clk) if (tx_push) tx_mem[tx_wr[AW-1:0]] <= bus_data_in;

  // TX FSM
  state_t        tx_state, tx_state_nx;
  logic [SW-1:0] tx_s, tx_s_nx;
  logic [NW-1:0] tx_n, tx_n_nx;
  logic [NB-1:0] tx_sh, tx_sh_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_sh    <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_s     <= tx_s_nx;
      tx_n     <= tx_n_nx;
      tx_sh    <= tx_sh_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_s_nx     = tx_s;
    tx_n_nx     = tx_n;
    tx_sh_nx    = tx_sh;
    unique case (tx_state)
      IDLE: if (!tx_empty) begin
`ifdef UART_SECDED_EN
        tx_sh_nx = encode(tx_mem[tx_rd[AW-1:0]]);
`else
        tx_sh_nx = tx_mem[tx_rd[AW-1:0]];
`endif
        tx_s_nx     = '0;
        tx_state_nx = START;
      end
      START: if (s_tick) begin
        if (tx_s == S_LAST) begin
          tx_s_nx     = '0;
          tx_n_nx     = '0;
          tx_state_nx = DATA;
        end else tx_s_nx = tx_s + 1'b1;
      end
      DATA: if (s_tick) begin
        if (tx_s == S_LAST) begin
          tx_s_nx  = '0;
          tx_sh_nx = tx_sh >> 1;
          if (tx_n == N_LAST) tx_state_nx = STOP;
          else                tx_n_nx     = tx_n + 1'b1;
        end else tx_s_nx = tx_s + 1'b1;
      end
      STOP: if (s_tick) begin
        if (tx_s == S_LAST) tx_state_nx = IDLE;
        else                tx_s_nx     = tx_s + 1'b1;
      end
    endcase
  end

  always_comb begin
    tx     = 1'b1;
    tx_pop = (tx_state == IDLE) && !tx_empty;
    unique case (tx_state)
      START:   tx = 1'b0;
      DATA:    tx = tx_sh[0];
      default: tx = 1'b1;
    endcase
  end

  assign baud_en            = (tx_state != IDLE);
  assign TX_status_register = {tx_full, tx_empty, baud_en};
  assign wait_request_write = tx_full;

  // RX input synchroniser, idles high
  logic [1:0] rx_sync;
  logic       rx_in;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_sync <= '1;
    else          rx_sync <= {rx_sync[0], rx};
  end
  assign rx_in = rx_sync[1];

  // RX FSM
  state_t        rx_state, rx_state_nx;
  logic [SW-1:0] rx_s, rx_s_nx;
  logic [NW-1:0] rx_n, rx_n_nx;
  logic [NB-1:0] rx_sh, rx_sh_nx;
  logic          rx_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= IDLE;
      rx_s     <= '0;
      rx_n     <= '0;
      rx_sh    <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_s     <= rx_s_nx;
      rx_n     <= rx_n_nx;
      rx_sh    <= rx_sh_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_s_nx     = rx_s;
    rx_n_nx     = rx_n;
    rx_sh_nx    = rx_sh;
    unique case (rx_state)
      IDLE: if (!rx_in) begin
        rx_s_nx     = '0;
        rx_state_nx = START;
      end
      START: if (s_tick) begin
        if (rx_s == S_MID) begin
          rx_s_nx     = '0;
          rx_n_nx     = '0;
          rx_state_nx = rx_in ? IDLE : DATA;
        end else rx_s_nx = rx_s + 1'b1;
      end
      DATA: if (s_tick) begin
        if (rx_s == S_LAST) begin
          rx_s_nx  = '0;
          rx_sh_nx = {rx_in, rx_sh[NB-1:1]};
          if (rx_n == N_LAST) rx_state_nx = STOP;
          else                rx_n_nx     = rx_n + 1'b1;
        end else rx_s_nx = rx_s + 1'b1;
      end
      STOP: if (s_tick) begin
        if (rx_s == S_LAST) rx_state_nx = IDLE;
        else                rx_s_nx     = rx_s + 1'b1;
      end
    endcase
  end

  always_comb begin
    rx_done = (rx_state == STOP) && s_tick && (rx_s == S_LAST) && rx_in;
  end

  // Decode and error status
  logic [DATA_SIZE-1:0] rx_byte;
  logic                 rx_keep;
  logic [1:0]           rx_err;
`ifdef UART_SECDED_EN
  logic [9:0] rx_dec;
  assign rx_dec  = decode(rx_sh);
  assign rx_byte = rx_dec[7:0];
  assign rx_keep = !rx_dec[9];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     rx_err <= '0;
    else if (rx_done) rx_err <= rx_dec[9:8];
  end
`else
  assign rx_byte = rx_sh;
  assign rx_keep = 1'b1;
  assign rx_err  = '0;
`endif

  // RX FIFO, first-word fall-through
  logic [DATA_SIZE-1:0] rx_mem [SIZE_FIFO];
  logic [AW:0]          rx_wr, rx_rd;
  logic                 rx_full, rx_empty, rx_push, rx_pop;
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign rx_push  = rx_done && rx_keep && !rx_full;
  assign rx_pop   = read_en && !rx_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
    end
  end
  always_ff @(posedge clk) if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_byte;

  assign rx_data_out        = rx_empty ? '0 : rx_mem[rx_rd[AW-1:0]];
  assign RX_status_register = {rx_err, rx_empty};
  assign wait_request_read  = rx_empty;
endmodule

// File: tb/tb_uart_sec_ded_top.sv
// Self-checking bench for uart_sec_ded_top: loopback, injected frames, FIFO full and mid-frame reset.
// Frame format follows UART_SECDED_EN, matching the RTL build.
module tb_uart_sec_ded_top;
`ifdef UART_SECDED_EN
  localparam int NB = 13;
`else
  localparam int NB = 8;
`endif
  localparam int BIT = 16 * 27;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       rx;
  logic       tx;
  logic       trans = 1'b0;
  logic [7:0] bus_data_in = '0;
  logic [2:0] TX_status_register;
  logic       baud_en;
  logic       read_en = 1'b0;
  logic [7:0] rx_data_out;
  logic [2:0] RX_status_register;
  logic       wait_request_read;
  logic       wait_request_write;
  logic       s_tick;

  logic loop = 1'b0;
  logic rx_drv = 1'b1;
  assign rx = loop ? tx : rx_drv;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  uart_sec_ded_top dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .rx                 (rx),
    .tx                 (tx),
    .trans              (trans),
    .bus_data_in        (bus_data_in),
    .TX_status_register (TX_status_register),
    .baud_en            (baud_en),
    .read_en            (read_en),
    .rx_data_out        (rx_data_out),
    .RX_status_register (RX_status_register),
    .wait_request_read  (wait_request_read),
    .wait_request_write (wait_request_write),
    .s_tick             (s_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    int         f1;
    int         f2;
    bit         stored;
    logic [7:0] exp;
    logic [1:0] st;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Parity bits are placed so the XOR of the indices of all set positions is zero.
  function automatic logic [NB-1:0] make_frame(input logic [7:0] d);
`ifdef UART_SECDED_EN
    int          dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    logic [12:0] pos;
    logic [3:0]  syn;
    pos = '0;
    syn = '0;
    for (int b = 0; b < 8; b++)
      if (d[b]) begin
        pos[dpos[b]] = 1'b1;
        syn = syn ^ 4'(dpos[b]);
      end
    for (int k = 0; k < 4; k++)
      if (syn[k]) pos[1 << k] = 1'b1;
    return {^pos, pos[12:1]};
`else
    return d;
`endif
  endfunction

  function automatic logic [NB-1:0] fmask(input int p);
    logic [NB-1:0] m;
    m = '0;
    if (p >= 1 && p <= NB) m[p-1] = 1'b1;
    return m;
  endfunction

  task automatic write_byte(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!s_tick && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_tick) chk("write_tick_timeout", 32'(s_tick), 32'd1);
    bus_data_in = d;
    trans = 1'b1;
    @(posedge clk);
    #1 trans = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk) read_en = 1'b1;
    @(negedge clk) read_en = 1'b0;
  endtask

  task automatic send_frame(input logic [NB-1:0] f);
    @(negedge clk) rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      rx_drv = f[i];
      repeat (BIT) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    send_frame(make_frame(v.data) ^ fmask(v.f1) ^ fmask(v.f2));
    chk({tag, "_err_flags"}, 32'(RX_status_register[2:1]), 32'(v.st));
    chk({tag, "_wait_read"}, 32'(wait_request_read), 32'(!v.stored));
    if (v.stored) begin
      chk({tag, "_data"}, 32'(rx_data_out), 32'(v.exp));
      pop();
      chk({tag, "_empty_after_pop"}, 32'(wait_request_read), 32'd1);
    end
  endtask

  initial begin
    vec_t        tbl [4];
    logic [7:0]  lb  [5];
    int unsigned t0;
    int          n;

`ifdef UART_SECDED_EN
    tbl[0] = '{8'hA5, 6, 0, 1'b1, 8'hA5, 2'b01};
    tbl[1] = '{8'hA5, 3, 9, 1'b0, 8'h00, 2'b10};
    tbl[2] = '{8'h3C, 13, 0, 1'b1, 8'h3C, 2'b01};
    tbl[3] = '{8'h5A, 0, 0, 1'b1, 8'h5A, 2'b00};
`else
    tbl[0] = '{8'hA5, 6, 0, 1'b1, 8'h85, 2'b00};
    tbl[1] = '{8'hA5, 3, 9, 1'b1, 8'hA1, 2'b00};
    tbl[2] = '{8'h3C, 13, 0, 1'b1, 8'h3C, 2'b00};
    tbl[3] = '{8'h5A, 0, 0, 1'b1, 8'h5A, 2'b00};
`endif
    lb = '{8'hFF, 8'h55, 8'hAB, 8'hCD, 8'hEA};

    // Reset values
    #1 reset_n = 1'b0;
    #12;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_baud_en", 32'(baud_en), 32'd0);
    chk("rst_s_tick", 32'(s_tick), 32'd0);
    chk("rst_rx_data", 32'(rx_data_out), 32'd0);
    chk("rst_tx_status", 32'(TX_status_register), 32'b010);
    chk("rst_rx_status", 32'(RX_status_register), 32'b001);
    chk("rst_wait_read", 32'(wait_request_read), 32'd1);
    chk("rst_wait_write", 32'(wait_request_write), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    // Baud tick period
    n = 0;
    while (!s_tick && n < 100) begin @(negedge clk); n++; end
    t0 = cyc;
    @(negedge clk);
    n = 0;
    while (!s_tick && n < 100) begin @(negedge clk); n++; end
    chk("tick_period", cyc - t0, 32'd27);

    repeat (1000) @(negedge clk);
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_tx_status", 32'(TX_status_register), 32'b010);
    chk("idle_rx_status", 32'(RX_status_register), 32'b001);

    // Loopback of five bytes
    loop = 1'b1;
    write_byte(lb[0]);
    n = 0;
    while (tx && n < 40) begin @(negedge clk); n++; end
    chk("tx_start_latency", 32'(tx), 32'd0);
    chk("tx_busy", 32'(TX_status_register[0]), 32'd1);
    for (int i = 1; i < 5; i++) write_byte(lb[i]);
    n = 0;
    while ((baud_en || !TX_status_register[1]) && n < 40000) begin @(negedge clk); n++; end
    chk("tx_drain", 32'(baud_en), 32'd0);
    repeat (200) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("loop_data%0d", i), 32'(rx_data_out), 32'(lb[i]));
      chk($sformatf("loop_flags%0d", i), 32'(RX_status_register[2:1]), 32'd0);
      pop();
    end
    chk("loop_rx_status_end", 32'(RX_status_register), 32'b001);
    loop = 1'b0;

    // Table of injected frames
    for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Random frames with 0..2 flipped positions
    for (int r = 0; r < 2; r++) begin
      vec_t v;
      int   nf, p1, p2;
      v.data = 8'($urandom);
      nf = int'($urandom_range(0, 2));
      p1 = int'($urandom_range(1, NB));
      p2 = int'($urandom_range(1, NB));
      while (p2 == p1) p2 = int'($urandom_range(1, NB));
      v.f1 = (nf >= 1) ? p1 : 0;
      v.f2 = (nf == 2) ? p2 : 0;
`ifdef UART_SECDED_EN
      v.stored = (nf < 2);
      v.exp    = v.data;
      v.st     = (nf == 2) ? 2'b10 : (nf == 1) ? 2'b01 : 2'b00;
`else
      v.stored = 1'b1;
      v.exp    = v.data ^ 8'(fmask(v.f1) ^ fmask(v.f2));
      v.st     = 2'b00;
`endif
      run_vec($sformatf("rnd%0d", r), v);
    end

    // TX FIFO full: first byte moves to the shifter, sixteen more fill the FIFO
    write_byte(8'h00);
    for (int i = 1; i < 16; i++) write_byte(8'(i));
    chk("wait_write_15_queued", 32'(wait_request_write), 32'd0);
    write_byte(8'h10);
    chk("wait_write_full", 32'(wait_request_write), 32'd1);
    chk("tx_status_full", 32'(TX_status_register), 32'b101);
    write_byte(8'h77);
    chk("tx_status_after_excess", 32'(TX_status_register), 32'b101);

    // Reset during the DATA state of the all-zero frame
    repeat (1000) @(negedge clk);
    chk("tx_low_in_data", 32'(tx), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_tx_status", 32'(TX_status_register), 32'b010);
    chk("midrst_baud_en", 32'(baud_en), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!tx) n++;
    end
    chk("no_resume_tx_low_cycles", 32'(n), 32'd0);
    chk("no_resume_tx_status", 32'(TX_status_register), 32'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
